// File: rtl/sub_serial32_if.sv
// ============================================================================
// Module   : sub_serial32_if
// Brief    : Start/ready request and valid/result bundle for sub_serial32.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sub_serial32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             lt;
  logic             eq;

  modport master (
    output start, a, b,
    input  ready, valid, diff, borrow, lt, eq
  );

  modport slave (
    input  start, a, b,
    output ready, valid, diff, borrow, lt, eq
  );
endinterface

`default_nettype wire

// File: rtl/sub_serial32.sv
// ============================================================================
// Module   : sub_serial32
// Brief    : Nibble-serial subtractor/comparator, a - b four bits per clock.
//            SUB_SERIAL32_CMP_EN enables the signed-less-than and equal flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sub_serial32 #(
  parameter int WIDTH = 32
) (
  input  wire logic     clk,
  input  wire logic     rst,
  sub_serial32_if.slave bus
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             ready_reg;
  logic             valid_reg;
`ifdef SUB_SERIAL32_CMP_EN
  logic             lt_reg;
  logic             eq_reg;
`endif

  logic [KW+1:0]    base;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       sum;
  logic [4:0]       cy;
  logic [WIDTH-1:0] diff_next;

  // One 4-bit ripple step on the nibble selected by k.
  always_comb begin
    base      = {k, 2'b00};
    nib_a     = a_reg[base +: 4];
    nib_b     = b_reg[base +: 4];
    cy        = '0;
    sum       = '0;
    cy[0]     = carry;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = nib_a[i] ^ nib_b[i] ^ cy[i];
      cy[i+1]  = (nib_a[i] & nib_b[i]) | (cy[i] & (nib_a[i] ^ nib_b[i]));
    end
    diff_next = diff_reg;
    diff_next[base +: 4] = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      carry      <= 1'b0;
      k          <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b0;
`ifdef SUB_SERIAL32_CMP_EN
      lt_reg     <= 1'b0;
      eq_reg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg      <= bus.a;
            b_reg      <= ~bus.b;
            carry      <= 1'b1;
            k          <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
`ifdef SUB_SERIAL32_CMP_EN
            lt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
`endif
            ready_reg  <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          diff_reg <= diff_next;
          carry    <= cy[4];
          k        <= k + 1'b1;
          if (k == K_LAST) begin
            borrow_reg <= ~cy[4];
`ifdef SUB_SERIAL32_CMP_EN
            // Signed overflow is carry-in XOR carry-out of the sign bit.
            lt_reg     <= sum[3] ^ (cy[3] ^ cy[4]);
            eq_reg     <= (diff_next == '0);
`endif
            valid_reg  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_reg;
  assign bus.valid  = valid_reg;
  assign bus.diff   = diff_reg;
  assign bus.borrow = borrow_reg;
`ifdef SUB_SERIAL32_CMP_EN
  assign bus.lt     = lt_reg;
  assign bus.eq     = eq_reg;
`else
  assign bus.lt     = 1'b0;
  assign bus.eq     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sub_serial32.sv
// ============================================================================
// Module   : tb_sub_serial32
// Brief    : Scoreboard bench for sub_serial32 (honours SUB_SERIAL32_CMP_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sub_serial32;

  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             lt;
    logic             eq;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nvalid = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_serial32_if #(.WIDTH(WIDTH)) bus ();

  sub_serial32 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int acc);
    exp_t e;
    e.diff   = a - b;
    e.borrow = (a < b);
`ifdef SUB_SERIAL32_CMP_EN
    e.lt     = ($signed(a) < $signed(b));
    e.eq     = (a == b);
`else
    e.lt     = 1'b0;
    e.eq     = 1'b0;
`endif
    e.acc    = acc;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("ready_timeout", 64'(bus.ready), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    wait_ready();
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    push(a, b, cyc);
    check("clr_diff", 64'(bus.diff), 64'd0);
    check("clr_flags", 64'({bus.borrow, bus.lt, bus.eq}), 64'd0);
    check("ready_low", 64'(bus.ready), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        nvalid++;
        if (sb.size() == 0) begin
          check("valid_unexp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("diff",    64'(bus.diff),   64'(e.diff));
          check("borrow",  64'(bus.borrow), 64'(e.borrow));
          check("lt",      64'(bus.lt),     64'(e.lt));
          check("eq",      64'(bus.eq),     64'(e.eq));
          check("latency", 64'(cyc - e.acc), 64'(N));
        end
      end
    end
  end

  initial begin
    int t0;
    int n;
    int v0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  64'(bus.ready), 64'd1);
    check("rst_valid",  64'(bus.valid), 64'd0);
    check("rst_diff",   64'(bus.diff),  64'd0);
    check("rst_flags",  64'({bus.borrow, bus.lt, bus.eq}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'd5, 32'd3);
    run_op(32'd3, 32'd5);
    run_op(32'h8000_0000, 32'd1);
    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Start during RUN is ignored.
    v0 = nvalid;
    wait_ready();
    bus.start = 1'b1;
    bus.a     = 32'd10;
    bus.b     = 32'd4;
    @(posedge clk);
    #1;
    push(32'd10, 32'd4, cyc);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    check("busy_single", 64'(nvalid - v0), 64'd1);

    // Start held high: re-armed N+1 cycles after acceptance, taken at once.
    wait_ready();
    bus.start = 1'b1;
    bus.a     = 32'd20;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    push(32'd20, 32'd7, cyc);
    t0 = cyc;
    n  = 0;
    @(negedge clk);
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rearm_gap", 64'(cyc - t0), 64'(N + 1));
    bus.a = 32'd9;
    bus.b = 32'd30;
    @(posedge clk);
    #1;
    push(32'd9, 32'd30, cyc);
    check("reaccept", 64'(bus.ready), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Reset three cycles into RUN discards the operation.
    v0 = nvalid;
    wait_ready();
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(bus.ready), 64'd1);
    check("midrst_diff",  64'(bus.diff),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_novalid", 64'(nvalid - v0), 64'd0);
    run_op(32'd7, 32'd7);
    drain();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", 1);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
